// File: rtl/lif_pkg.sv
// Shared defaults and types for the leaky integrate-and-fire neuron.
// Optional refractory behaviour is enabled by defining LIF_REFRACTORY_EN.
package lif_pkg;

  localparam int WIDTH              = 8;
  localparam int THRESHOLD_DEF      = 100;
  localparam int LEAK_DEF           = 1;
  localparam int WEIGHT_DEF         = 10;
  localparam int REFRACT_CYCLES_DEF = 2;

  typedef logic [WIDTH-1:0] vmem_t;

  // Bit width needed to hold a refractory count (at least one bit).
  function automatic int refract_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/lif_sat_arith.sv
// Saturating integrate followed by floored leak.
// s = min(v + (spike ? WEIGHT : 0), 2^WIDTH-1); l = (s > LEAK) ? s - LEAK : 0.
module lif_sat_arith #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] LEAK   = 1,
  parameter logic [WIDTH-1:0] WEIGHT = 10
) (
  input  logic [WIDTH-1:0] v,
  input  logic             spike,
  output logic [WIDTH-1:0] l
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s;

  // One extra bit catches overflow, which clamps to all-ones before the leak.
  always_comb begin
    sum = {1'b0, v} + (spike ? {1'b0, WEIGHT} : '0);
    s   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    l   = (s > LEAK) ? (s - LEAK) : '0;
  end

endmodule

// File: rtl/lif_neuron.sv
// Single leaky integrate-and-fire neuron with reset-to-zero on fire.
// Define LIF_REFRACTORY_EN to hold the neuron silent for REFRACT_CYCLES
// cycles after each fire.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int unsigned      WIDTH          = lif_pkg::WIDTH,
  parameter logic [WIDTH-1:0] THRESHOLD      = WIDTH'(THRESHOLD_DEF),
  parameter logic [WIDTH-1:0] LEAK           = WIDTH'(LEAK_DEF),
  parameter logic [WIDTH-1:0] WEIGHT         = WIDTH'(WEIGHT_DEF),
  parameter int               REFRACT_CYCLES = REFRACT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  output logic             spike_out,
  output logic [WIDTH-1:0] v_mem
);

  // Parameter sets that could never fire, or could fire twice in a row, are rejected.
  if (THRESHOLD == '0) begin : g_bad_threshold
    $error("lif_neuron: THRESHOLD must be nonzero");
  end
  if (WEIGHT <= LEAK) begin : g_bad_weight
    $error("lif_neuron: WEIGHT must exceed LEAK");
  end
  if (THRESHOLD <= WEIGHT) begin : g_bad_thr_weight
    $error("lif_neuron: THRESHOLD must exceed WEIGHT");
  end
  if (REFRACT_CYCLES < 0) begin : g_bad_refract
    $error("lif_neuron: REFRACT_CYCLES must be non-negative");
  end

  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] v_next;
  logic             spike_next;

  lif_sat_arith #(
    .WIDTH  (WIDTH),
    .LEAK   (LEAK),
    .WEIGHT (WEIGHT)
  ) u_arith (
    .v     (v_mem),
    .spike (spike_in),
    .l     (leaked)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RW = refract_width(REFRACT_CYCLES);

  logic [RW-1:0] refract_q;
  logic [RW-1:0] refract_next;

  // During refractory the potential is pinned at 0 and input spikes are dropped.
  always_comb begin
    v_next       = leaked;
    spike_next   = 1'b0;
    refract_next = refract_q;
    if (refract_q != '0) begin
      v_next       = '0;
      refract_next = refract_q - RW'(1);
    end else if (leaked >= THRESHOLD) begin
      v_next       = '0;
      spike_next   = 1'b1;
      refract_next = RW'(REFRACT_CYCLES);
    end
  end

  // Refractory counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) refract_q <= '0;
    else     refract_q <= refract_next;
  end
`else
  // Fire when the post-leak potential reaches threshold, else keep it.
  always_comb begin
    v_next     = leaked;
    spike_next = 1'b0;
    if (leaked >= THRESHOLD) begin
      v_next     = '0;
      spike_next = 1'b1;
    end
  end
`endif

  // Membrane potential and fire pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_mem     <= '0;
      spike_out <= 1'b0;
    end else begin
      v_mem     <= v_next;
      spike_out <= spike_next;
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed scenarios plus random spikes,
// compared against a plain-arithmetic reference model.
module tb_lif_neuron;

  localparam int MAXV = 255;
`ifdef LIF_REFRACTORY_EN
  localparam int RC = 2;
`else
  localparam int RC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa = 1'b0, sb = 1'b0;
  logic       out_a, out_b;
  logic [7:0] v_a, v_b;

  int n_checks = 0;
  int n_fail   = 0;

  int ma_v = 0, ma_o = 0, ma_r = 0;
  int mb_v = 0, mb_o = 0, mb_r = 0;

  lif_neuron #(.WIDTH(8), .THRESHOLD(8'd60), .LEAK(8'd5), .WEIGHT(8'd10),
               .REFRACT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .spike_in(sa), .spike_out(out_a), .v_mem(v_a));

  lif_neuron #(.WIDTH(8), .THRESHOLD(8'd255), .LEAK(8'd1), .WEIGHT(8'd250),
               .REFRACT_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .spike_in(sb), .spike_out(out_b), .v_mem(v_b));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of the neuron in plain arithmetic.
  task automatic model_step(input int thr, input int leak, input int wt, input bit sp,
                            inout int v, inout int o, inout int r);
    int s, l;
    s = v + (sp ? wt : 0);
    if (s > MAXV) s = MAXV;
    l = (s > leak) ? s - leak : 0;
    if (r > 0) begin
      v = 0; o = 0; r = r - 1;
    end else if (l >= thr) begin
      v = 0; o = 1; r = RC;
    end else begin
      v = l; o = 0;
    end
  endtask

  task automatic model_reset();
    ma_v = 0; ma_o = 0; ma_r = 0;
    mb_v = 0; mb_o = 0; mb_r = 0;
  endtask

  // Drive inputs (1 ns after the previous edge), clock once, compare 1 ns later.
  task automatic tick(input bit r, input bit a, input bit b);
    rst = r; sa = a; sb = b;
    @(posedge clk);
    if (r) model_reset();
    else begin
      model_step(60, 5, 10, a, ma_v, ma_o, ma_r);
      model_step(255, 1, 250, b, mb_v, mb_o, mb_r);
    end
    #1;
    check("a_v_mem", int'(v_a), ma_v);
    check("a_spike", int'(out_a), ma_o);
    check("b_v_mem", int'(v_b), mb_v);
    check("b_spike", int'(out_b), mb_o);
  endtask

  initial begin
    int fires[$];
    int f0, f1;

    // Scenario 1: reset then idle.
    @(posedge clk); #1;
    check("s1_reset_v", int'(v_a), 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    check("s1_idle_v", int'(v_a), 0);
    check("s1_idle_spike", int'(out_a), 0);

    // Scenario 2 (and 6 when refractory is built in): continuous input.
    for (int k = 1; k <= 30; k++) begin
      tick(0, 1, 0);
      if (k <= 11) check("s2_ramp", int'(v_a), 5 * k);
      if (out_a) fires.push_back(k);
    end
    f0 = (fires.size() > 0) ? fires[0] : -1;
    f1 = (fires.size() > 1) ? fires[1] : -1;
    check("s2_fire_count", fires.size(), 2);
    check("s2_first_fire", f0, 12);
`ifdef LIF_REFRACTORY_EN
    check("s6_second_fire", f1, 26);
    check("s6_v_after_30", int'(v_a), 10);
`else
    check("s2_second_fire", f1, 24);
    check("s2_v_after_30", int'(v_a), 30);
`endif

    // Scenario 3: leak down and floor at 0.
    for (int k = 0; k < 10; k++) tick(0, 0, 0);
    check("s3_floor_v", int'(v_a), 0);

    // Scenario 4: integrate, then asynchronous reset mid-cycle.
    for (int k = 0; k < 5; k++) tick(0, 1, 1);
    check("s4_v_before_rst", int'(v_a), 25);
    #3 rst = 1'b1;
    #1;
    check("s4_async_v", int'(v_a), 0);
    check("s4_async_spike", int'(out_a), 0);
    check("s4_async_vb", int'(v_b), 0);
    model_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0);
    check("s4_post_rst_v", int'(v_a), 0);

    // Scenario 5: saturation on the wide-weight neuron.
    tick(0, 0, 1);
    check("s5_first_v", int'(v_b), 249);
    tick(0, 0, 1);
    check("s5_sat_v", int'(v_b), 254);
    for (int k = 0; k < 4; k++) tick(0, 0, 1);
    check("s5_hold_v", int'(v_b), 254);
    check("s5_no_fire", int'(out_b), 0);

    // Random spikes with occasional resets.
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Single leaky integrate-and-fire (LIF) neuron.
- Integrates binary input spikes into an unsigned membrane potential, applies a constant linear leak every cycle, and emits a one-cycle output spike on crossing threshold.
- Leaf compute element, instantiated per neuron in the spiking-network fabric; v_mem is exported for observation and debug.

Parameters:
- WIDTH, 8, bit width of membrane potential and of THRESHOLD/LEAK/WEIGHT.
- THRESHOLD, 8'd100, firing threshold; fire when post-leak potential >= THRESHOLD.
- LEAK, 8'd1, constant subtracted every cycle, floored at 0.
- WEIGHT, 8'd10, amount added per cycle while spike_in=1.
- REFRACT_CYCLES, 2, refractory length in cycles; used only with the optional feature.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- spike_in, input, 1, synchronous input spike, sampled each rising edge.
- spike_out, output, 1, registered fire pulse, high for exactly one cycle per fire.
- v_mem, output, WIDTH, registered membrane potential.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: v_mem=0, spike_out=0, immediately on rst assertion, independent of clk. Refractory counter=0. Reset mid-operation discards all state; integration restarts from 0 on the first edge after release.
- Per rising edge, with v = current v_mem:
  - Integrate: s = v + (spike_in ? WEIGHT : 0), computed at WIDTH+1 bits and saturated to 2^WIDTH-1.
  - Leak: l = (s > LEAK) ? s - LEAK : 0. No underflow; v_mem never wraps below 0.
  - Fire: if l >= THRESHOLD, then spike_out<=1 and v_mem<=0 (reset-to-zero). Otherwise spike_out<=0 and v_mem<=l.
- Latency: a spike_in sampled at edge N affects v_mem and spike_out after edge N. spike_out rises on the same edge that v_mem returns to 0.
- spike_out never stays high for two consecutive cycles: v_mem is 0 after a fire, and THRESHOLD > WEIGHT is required.
- Static parameter legality (elaboration check/assert): THRESHOLD > 0, WEIGHT > LEAK (else the neuron can never fire), THRESHOLD > WEIGHT.
- spike_in=0 with v_mem=0: v_mem stays 0, spike_out=0.
- Fully synchronous datapath apart from reset; no handshake and no backpressure.

Optional Feature:
- Macro LIF_REFRACTORY_EN.
- Defined: after a fire, a counter loads REFRACT_CYCLES. While the counter is nonzero, spike_in is ignored, v_mem is held at 0, spike_out=0, and the counter decrements each cycle. Normal integration resumes on the cycle after the counter reaches 0.
- Undefined: no counter logic, no refractory period; integration resumes on the cycle immediately after a fire.

Decomposition:
- Package lif_pkg:
  - WIDTH default;
  - default THRESHOLD/LEAK/WEIGHT/REFRACT_CYCLES localparams;
  - typedef vmem_t (logic [WIDTH-1:0]).
- Optional sub-module lif_sat_arith: combinational saturating add followed by floored subtract (s, l above). Reusable by multi-synapse neuron variants.
- Fire/reset register logic stays in lif_neuron.

Test Plan:
All scenarios use THRESHOLD=60, LEAK=5, WEIGHT=10, feature off unless stated; spike_in changes 1 ns after the rising edge.
1. Hold rst 2 cycles, release, spike_in=0 -> v_mem=0 and spike_out=0 throughout; assert rst asynchronously between edges -> outputs are 0 before the next edge.
2. spike_in=1 for 30 cycles -> v_mem = 5, 10, ..., 55; on the 12th edge spike_out=1 and v_mem=0; second fire on the 24th edge; v_mem=30 after the 30th edge; spike_out high exactly 2 single cycles.
3. From v_mem=30, spike_in=0 for 10 cycles -> 25, 20, 15, 10, 5, 0, then held at 0 (no underflow); spike_out=0.
4. spike_in=1 for 5 cycles (v_mem=25), then rst for 2 cycles -> v_mem=0; after release with spike_in=0, v_mem stays 0.
5. Saturation: WIDTH=8, THRESHOLD=255, WEIGHT=250, LEAK=1, spike_in=1 -> v_mem=249, then 255-1=254 (saturated add, no wrap); no fire until l >= 255, and l is never 255 here.
6. With LIF_REFRACTORY_EN, REFRACT_CYCLES=2, continuous spike_in=1 -> after the fire at edge 12, v_mem=0 for 2 more edges, then 5, 10, ...; next fire at edge 26.
